// File: rtl/single_port_ram_be_pipe.sv
// single_port_ram_be_pipe
// Single-port synchronous RAM with per-byte write enables, a 1- or 2-cycle
// read pipeline with a q_valid strobe, selectable read-during-write result,
// and an optional hardware clear sweep that zeroes the array after reset.

module single_port_ram_be_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BYTE_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            data,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
    input  logic                             re,
    output logic [DATA_WIDTH-1:0]            q,
    output logic                             q_valid,
    output logic                             busy
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // Reject parameter sets the lane slicing and read pipeline cannot honour.
    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_badByteWidth
            $fatal(1, "DATA_WIDTH must be an integer multiple of BYTE_WIDTH");
        end
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_badLatency
            $fatal(1, "RD_LATENCY must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_clearCnt;
    logic                  w_clearWrite;
    logic                  w_accessEn;
    logic                  w_writeEn;
    logic                  w_readEn;
    logic [DATA_WIDTH-1:0] w_oldWord;
    logic [DATA_WIDTH-1:0] w_mergedWord;
    logic [DATA_WIDTH-1:0] w_capturedWord;

    logic [DATA_WIDTH-1:0] r_rdData1;
    logic                  r_rdValid1;

    // State register: reset picks the sweep or goes straight to normal use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: the sweep ends on the edge that writes the last word.
    always_comb begin
        w_nextState  = r_state;
        w_clearWrite = 1'b0;
        w_accessEn   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clearWrite = 1'b1;
                if (r_clearCnt == LAST_ADDR) begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_accessEn = 1'b1;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state == ST_CLEAR);
    assign w_writeEn = w_accessEn & we & ~rst;
    assign w_readEn  = w_accessEn & re & ~rst;

    // Sweep address counter; restarts from zero on every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clearCnt <= '0;
        end else if (w_clearWrite) begin
            r_clearCnt <= r_clearCnt + 1'b1;
        end
    end

    assign w_oldWord = r_mem[addr];

    // Post-write view of the addressed word, used for new-data read-during-write.
    always_comb begin
        w_mergedWord = w_oldWord;
        for (int i = 0; i < NB; i++) begin
            if (w_writeEn && be[i]) begin
                w_mergedWord[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign w_capturedWord = (RDW_MODE == 0) ? w_mergedWord : w_oldWord;

    // Array update: sweep zeroes one word per cycle, otherwise byte-lane writes; reset never touches contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clearWrite) begin
                r_mem[r_clearCnt] <= '0;
            end else if (w_writeEn) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        r_mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // First read stage: captures the word on the request edge and holds it between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData1  <= '0;
            r_rdValid1 <= 1'b0;
        end else begin
            r_rdValid1 <= w_readEn;
            if (w_readEn) begin
                r_rdData1 <= w_capturedWord;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] r_rdData2;
            logic                  r_rdValid2;

            // Second read stage: extra output register that only loads on a valid result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdData2  <= '0;
                    r_rdValid2 <= 1'b0;
                end else begin
                    r_rdValid2 <= r_rdValid1;
                    if (r_rdValid1) begin
                        r_rdData2 <= r_rdData1;
                    end
                end
            end

            assign q       = r_rdData2;
            assign q_valid = r_rdValid2;
        end else begin : g_lat1
            assign q       = r_rdData1;
            assign q_valid = r_rdValid1;
        end
    endgenerate

endmodule

// File: tb/tb_single_port_ram_be_pipe.sv
// tb_single_port_ram_be_pipe
// Directed self-checking bench. Three instances share one stimulus stream:
//   A: latency 1, new-data read-during-write, clear sweep on reset
//   B: latency 2, old-data read-during-write, clear sweep on reset
//   C: latency 1, no clear sweep
// Outputs are sampled on the falling edge, inputs driven there too.

module tb_single_port_ram_be_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic [3:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic        re;

    logic [31:0] qA, qB, qC;
    logic        qValidA, qValidB, qValidC;
    logic        busyA, busyB, busyC;

    int testCount = 0;
    int failCount = 0;

    single_port_ram_be_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dutA (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .be(be), .re(re),
        .q(qA), .q_valid(qValidA), .busy(busyA)
    );

    single_port_ram_be_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dutB (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .be(be), .re(re),
        .q(qB), .q_valid(qValidB), .busy(busyB)
    );

    single_port_ram_be_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(0)
    ) dutC (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .be(be), .re(re),
        .q(qC), .q_valid(qValidC), .busy(busyC)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return at the next falling edge with outputs settled.
    task automatic applyStimulus(input logic iWe, input logic iRe, input logic [3:0] iBe,
                                 input logic [3:0] iAddr, input logic [31:0] iData);
        we   = iWe;
        re   = iRe;
        be   = iBe;
        addr = iAddr;
        data = iData;
        @(negedge clk);
    endtask

    // Single read checked on A after one cycle and on B after two.
    task automatic readBoth(input string tag, input logic [3:0] rdAddr,
                            input logic [31:0] expA, input logic [31:0] expB);
        applyStimulus(1'b0, 1'b1, 4'h0, rdAddr, 32'h0);
        checkOutput({tag, "_qvA"}, 32'(qValidA), 32'd1);
        checkOutput({tag, "_qA"}, qA, expA);
        checkOutput({tag, "_qvB_early"}, 32'(qValidB), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput({tag, "_qvB"}, 32'(qValidB), 32'd1);
        checkOutput({tag, "_qB"}, qB, expB);
        checkOutput({tag, "_qvA_drop"}, 32'(qValidA), 32'd0);
    endtask

    initial begin
        int busyCntA;
        int busyCntB;
        int sweepValid;
        logic [31:0] expQA  [5];
        logic [31:0] expQB  [5];
        logic        expQvA [5];
        logic        expQvB [5];
        logic [3:0]  pipeAddr [3];

        rst  = 1'b1;
        we   = 1'b0;
        re   = 1'b0;
        be   = 4'h0;
        addr = 4'h0;
        data = 32'h0;
        @(negedge clk);
        @(negedge clk);

        checkOutput("rst_qA", qA, 32'h0);
        checkOutput("rst_qvA", 32'(qValidA), 32'd0);
        checkOutput("rst_qB", qB, 32'h0);
        checkOutput("rst_qvB", 32'(qValidB), 32'd0);
        checkOutput("rst_busyA", 32'(busyA), 32'd1);
        checkOutput("rst_busyB", 32'(busyB), 32'd1);
        checkOutput("rst_busyC", 32'(busyC), 32'd0);

        rst        = 1'b0;
        busyCntA   = 0;
        busyCntB   = 0;
        sweepValid = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busyA && !busyB) break;
            if (busyA) busyCntA++;
            if (busyB) busyCntB++;
            if (qValidA || qValidB) sweepValid++;
            if (k == 0) checkOutput("noclr_busyC", 32'(busyC), 32'd0);
            if (k == 2) begin
                checkOutput("noclr_qvC", 32'(qValidC), 32'd1);
                checkOutput("noclr_qC", qC, 32'hCAFEF00D);
            end
            if (k == 0)      applyStimulus(1'b1, 1'b0, 4'hF, 4'd9, 32'hCAFEF00D);
            else if (k == 1) applyStimulus(1'b0, 1'b1, 4'h0, 4'd9, 32'h0);
            else if (k == 8) applyStimulus(1'b1, 1'b1, 4'hF, 4'd0, 32'hDEADBEEF);
            else             applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        end
        checkOutput("sweep_busyA_cycles", 32'(busyCntA), 32'd16);
        checkOutput("sweep_busyB_cycles", 32'(busyCntB), 32'd16);
        checkOutput("sweep_no_qvalid", 32'(sweepValid), 32'd0);

        for (int i = 0; i < 16; i++) begin
            readBoth($sformatf("clr%0d", i), 4'(i), 32'h0, 32'h0);
        end

        applyStimulus(1'b1, 1'b0, 4'b1111, 4'd5, 32'hAABBCCDD);
        applyStimulus(1'b1, 1'b0, 4'b0101, 4'd5, 32'h11223344);
        readBoth("lanes", 4'd5, 32'hAA22CC44, 32'hAA22CC44);
        applyStimulus(1'b1, 1'b0, 4'b0000, 4'd5, 32'hFFFFFFFF);
        readBoth("be0", 4'd5, 32'hAA22CC44, 32'hAA22CC44);

        applyStimulus(1'b1, 1'b0, 4'hF, 4'd1, 32'h10);
        applyStimulus(1'b1, 1'b0, 4'hF, 4'd2, 32'h20);
        applyStimulus(1'b1, 1'b0, 4'hF, 4'd3, 32'h30);
        pipeAddr = '{4'd1, 4'd2, 4'd3};
        expQvA = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        expQA  = '{32'h10, 32'h20, 32'h30, 32'h30, 32'h30};
        expQvB = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        expQB  = '{32'hAA22CC44, 32'h10, 32'h20, 32'h30, 32'h30};
        for (int s = 0; s < 5; s++) begin
            if (s < 3) applyStimulus(1'b0, 1'b1, 4'h0, pipeAddr[s], 32'h0);
            else       applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
            checkOutput($sformatf("pipe%0d_qvA", s), 32'(qValidA), 32'(expQvA[s]));
            checkOutput($sformatf("pipe%0d_qA", s), qA, expQA[s]);
            checkOutput($sformatf("pipe%0d_qvB", s), 32'(qValidB), 32'(expQvB[s]));
            checkOutput($sformatf("pipe%0d_qB", s), qB, expQB[s]);
        end

        applyStimulus(1'b1, 1'b1, 4'b0011, 4'd7, 32'hFFFFFFFF);
        checkOutput("rdw_qvA", 32'(qValidA), 32'd1);
        checkOutput("rdw_new_qA", qA, 32'h0000FFFF);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("rdw_qvB", 32'(qValidB), 32'd1);
        checkOutput("rdw_old_qB", qB, 32'h00000000);
        readBoth("rdw_after", 4'd7, 32'h0000FFFF, 32'h0000FFFF);

        applyStimulus(1'b1, 1'b0, 4'hF, 4'd14, 32'h5A5A5A5A);
        applyStimulus(1'b0, 1'b1, 4'h0, 4'd2, 32'h0);
        checkOutput("inflight_qA", qA, 32'h20);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("inflight_qvB", 32'(qValidB), 32'd0);
        checkOutput("inflight_qB", qB, 32'h0);
        checkOutput("inflight_qvA", 32'(qValidA), 32'd0);
        checkOutput("inflight_qA_rst", qA, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("inflight_qvB_late", 32'(qValidB), 32'd0);

        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        checkOutput("restart_busyA", 32'(busyA), 32'd1);
        rst      = 1'b0;
        busyCntA = 0;
        busyCntB = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busyA && !busyB) break;
            if (busyA) busyCntA++;
            if (busyB) busyCntB++;
            applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        end
        checkOutput("restart_busyA_cycles", 32'(busyCntA), 32'd16);
        checkOutput("restart_busyB_cycles", 32'(busyCntB), 32'd16);
        readBoth("restart_clr14", 4'd14, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/single_port_ram_be_pipe.md
Name: single_port_ram_be_pipe

Overview:
Parametrised single-port synchronous RAM. Adds per-byte write enables, a selectable read latency of 1 or 2 cycles with a q_valid strobe, and a selectable read-during-write mode. After reset it runs a hardware clear sweep that zeroes every word. It is the drop-in storage primitive for SoC building blocks that need a byte-writable scratchpad with a known power-up state.

Parameters:
DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH
ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words
BYTE_WIDTH, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes
RD_LATENCY, 1, cycles from re sampled to q valid; legal values 1 or 2
RDW_MODE, 0, read-during-write result: 0 = new (merged) data, 1 = old data
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the sweep (contents undefined)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
data  input  DATA_WIDTH  write data
addr  input  ADDR_WIDTH  read/write address (shared)
we  input  1  write request
be  input  NB  byte-lane write enables; lane i covers data[i*BYTE_WIDTH +: BYTE_WIDTH]
re  input  1  read request
q  output  DATA_WIDTH  read data; holds its last value between reads
q_valid  output  1  one-cycle strobe: q carries the result of a read
busy  output  1  clear sweep in progress; we/re ignored

Behaviour:
- Single clock domain: clk, with synchronous active-high reset rst. All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - q=0, q_valid=0, pipeline valid bits=0, clear counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else to IDLE.
  - busy=1 when entering CLEAR, 0 when entering IDLE.
  - Array contents are untouched by rst itself.
- FSM CLEAR:
  - Each cycle writes 0 to word[cnt], then cnt++.
  - When cnt = 2**ADDR_WIDTH-1 is written, the next state is IDLE and busy drops on that edge.
  - The sweep takes exactly 2**ADDR_WIDTH cycles after reset deasserts.
  - we, re, be and data are ignored; no q_valid is produced.
  - rst during CLEAR restarts the sweep from cnt=0.
- FSM IDLE: normal operation; busy=0. No other states exist.
- Write (IDLE, we=1):
  - For each lane i with be[i]=1, word[addr] lane i <= data lane i. Lanes with be[i]=0 keep their value.
  - we=1 with be=0 performs no write and is legal.
- Read (IDLE, re=1):
  - Stage 1 captures the word at addr on the same edge.
  - RD_LATENCY=1: q updates and q_valid=1 in the cycle immediately after the re edge.
  - RD_LATENCY=2: q and q_valid appear one cycle later through an additional output register.
  - Back-to-back reads are fully pipelined: one result per cycle, in request order.
  - q is unchanged when q_valid=0.
- Read-during-write (re=1 and we=1 on the same edge):
  - RDW_MODE=0: q returns the post-write word. Enabled lanes carry new data; disabled lanes carry old contents.
  - RDW_MODE=1: q returns the full pre-write word.
  - The write always completes regardless of mode.
- Reads in flight when rst asserts are discarded; no q_valid follows.
- Address wraps naturally; there is no out-of-range condition.
- Elaboration checks: DATA_WIDTH % BYTE_WIDTH != 0 and RD_LATENCY not in {1,2} are fatal errors.

Test Plan:
1. Clear sweep (ADDR_WIDTH=4, CLEAR_ON_RESET=1): rst for 2 cycles, then release.
   -> busy=1 for exactly 16 cycles. Reads of addresses 0..15 afterwards return 0x00000000.
   Also: we=1 issued mid-sweep -> the write is ignored.
2. Byte-lane write: write 0xAABBCCDD at addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
   -> read of addr 5 returns 0xAA22CC44.
   Also: we=1 with be=0 -> word is unchanged.
3. Latency and pipelining: RD_LATENCY=1 and 2, re on 3 consecutive cycles at addr 1, 2, 3 (preloaded 0x10, 0x20, 0x30).
   -> q_valid asserts 1 (resp. 2) cycles after the first re, stays high 3 cycles, q = 0x10, 0x20, 0x30.
   -> q holds 0x30 afterwards.
4. Read-during-write: word at addr 7 = 0x00000000; same edge re=1, we=1, be=4'b0011, data=0xFFFFFFFF.
   -> RDW_MODE=0 returns 0x0000FFFF; RDW_MODE=1 returns 0x00000000.
   -> A subsequent read returns 0x0000FFFF in both modes.
5. Reset mid-operation: rst at CLEAR cycle 6 -> sweep restarts, busy high for a full 16 cycles.
   Also: rst asserted while a RD_LATENCY=2 read is in flight -> no q_valid, q=0.
6. CLEAR_ON_RESET=0: after rst release -> busy=0 in the first cycle, and a write followed by a read works immediately.
